// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART transmitter among N_REQ word streams.
// It can optionally send a source tag word ahead of each data word.
module uart_tx_arbiter #(
   parameter int WIDTH = 8,
   parameter int N_REQ = 4,
   parameter int TAG_EN = 1,
   parameter logic [WIDTH-1:0] TAG_BASE = 8'hF0,
   localparam int IDW = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
   input  logic                   clk,
   input  logic                   i_reset,
   input  logic [N_REQ*WIDTH-1:0] i_req_data,
   input  logic [N_REQ-1:0]       i_req_valid,
   output logic [N_REQ-1:0]       o_req_ready,
   output logic [WIDTH-1:0]       o_tx_data,
   output logic                   o_tx_start,
   input  logic                   i_tx_busy,
   output logic [IDW-1:0]         o_grant_id,
   output logic                   o_active
);

   typedef enum logic [1:0] {IDLE, WAIT_TAG, DATA, WAIT_DATA} state_t;

   state_t           state, state_next;
   logic [IDW-1:0]   grant_q, last_grant, pick, scan_idx;
   logic             scan_found, any_valid, tx_done;
   logic [WIDTH-1:0] tag_word, sel_word;
   logic [WIDTH-1:0] words [N_REQ];

   assign any_valid  = |i_req_valid;
   // The start-pulse cycle itself never counts as completion, whatever busy says.
   assign tx_done    = !o_tx_start && !i_tx_busy;
   assign tag_word   = TAG_BASE + WIDTH'(pick);
   assign sel_word   = words[grant_q];
   assign o_grant_id = grant_q;

   always_comb begin
      for (int k = 0; k < N_REQ; k++) begin
         words[k] = i_req_data[k*WIDTH +: WIDTH];
      end
   end

   // The scan starts just after the last grantee, so the first hit wins the round.
   always_comb begin
      pick       = '0;
      scan_idx   = '0;
      scan_found = 1'b0;
      for (int i = 1; i <= N_REQ; i++) begin
         scan_idx = IDW'((int'(last_grant) + i) % N_REQ);
         if (!scan_found && i_req_valid[scan_idx]) begin
            pick       = scan_idx;
            scan_found = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge i_reset) begin
      if (i_reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:      if (any_valid) state_next = (TAG_EN != 0) ? WAIT_TAG : DATA;
         WAIT_TAG:  if (tx_done) state_next = DATA;
         DATA:      if (i_req_valid[grant_q]) state_next = WAIT_DATA;
         WAIT_DATA: if (tx_done) state_next = IDLE;
         default:   state_next = IDLE;
      endcase
   end

   always_comb begin
      o_req_ready = '0;
      if (state == DATA) begin
         o_req_ready[grant_q] = 1'b1;
      end
      o_active = (state != IDLE);
   end

   // last_grant starts at the top id so requester 0 is first in line after reset.
   always_ff @(posedge clk or posedge i_reset) begin
      if (i_reset) begin
         grant_q    <= '0;
         last_grant <= IDW'(N_REQ - 1);
         o_tx_data  <= '0;
         o_tx_start <= 1'b0;
      end else begin
         o_tx_start <= 1'b0;
         case (state)
            IDLE: begin
               if (any_valid) begin
                  grant_q <= pick;
                  if (TAG_EN != 0) begin
                     o_tx_data  <= tag_word;
                     o_tx_start <= 1'b1;
                  end
               end
            end
            DATA: begin
               if (i_req_valid[grant_q]) begin
                  o_tx_data  <= sel_word;
                  o_tx_start <= 1'b1;
               end
            end
            WAIT_DATA: begin
               if (tx_done) last_grant <= grant_q;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: a tagged instance and an untagged instance.
// Each instance is driven against a simple busy-counter transmitter model.
module tb_uart_tx_arbiter;

   localparam int W = 8;
   localparam int N = 4;

   logic           clk = 1'b0;
   logic           rst;
   logic [N*W-1:0] req_data, req_data0;
   logic [N-1:0]   req_valid, req_valid0, req_ready, req_ready0, oneshot;
   logic [W-1:0]   tx_data, tx_data0;
   logic           tx_start, tx_start0, tx_busy, tx_busy0;
   logic [1:0]     grant_id, grant_id0;
   logic           active, active0;

   int checks = 0;
   int errors = 0;
   int busy_len, bcnt, bcnt0, overlap, overlap0;
   logic [7:0] log_q[$];
   logic [7:0] log0_q[$];
   int hs_q[$];
   int rdy_cnt[N];
   logic [N-1:0] s_ready, s_ready0, s_hs;
   logic s_start0;
   logic [7:0] s_data0;

   typedef struct {
      int         id;
      logic [7:0] word;
      logic [7:0] exp_tag;
   } vec_t;
   vec_t vecs[4];

   always #5 clk = ~clk;

   uart_tx_arbiter #(.WIDTH(W), .N_REQ(N), .TAG_EN(1), .TAG_BASE(8'hF0)) dut (
      .clk(clk), .i_reset(rst), .i_req_data(req_data), .i_req_valid(req_valid),
      .o_req_ready(req_ready), .o_tx_data(tx_data), .o_tx_start(tx_start),
      .i_tx_busy(tx_busy), .o_grant_id(grant_id), .o_active(active));

   uart_tx_arbiter #(.WIDTH(W), .N_REQ(N), .TAG_EN(0), .TAG_BASE(8'hF0)) dut0 (
      .clk(clk), .i_reset(rst), .i_req_data(req_data0), .i_req_valid(req_valid0),
      .o_req_ready(req_ready0), .o_tx_data(tx_data0), .o_tx_start(tx_start0),
      .i_tx_busy(tx_busy0), .o_grant_id(grant_id0), .o_active(active0));

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, want %0h", name, actual, expected);
      end
   endtask

   task automatic timeoutFail(input string name);
      checks++;
      errors++;
      $display("[TB] FAIL %s: wait bound expired", name);
   endtask

   function automatic logic [7:0] logAt(input int i);
      if (i < log_q.size()) return log_q[i];
      return 'x;
   endfunction

   // One clock: sample mid-cycle, run the transmitter models, then release handshaken words.
   task automatic cycle();
      logic [N-1:0] hs, hs0;
      @(negedge clk);
      s_ready  = req_ready;
      s_ready0 = req_ready0;
      s_start0 = tx_start0;
      s_data0  = tx_data0;
      hs   = req_ready & req_valid;
      hs0  = req_ready0 & req_valid0;
      s_hs = hs;
      for (int k = 0; k < N; k++) begin
         if (hs[k]) hs_q.push_back(k);
         if (req_ready[k]) rdy_cnt[k]++;
      end
      if (tx_start) begin
         log_q.push_back(tx_data);
         if (tx_busy) overlap++;
      end
      if (tx_start0) begin
         log0_q.push_back(tx_data0);
         if (tx_busy0) overlap0++;
      end
      if (tx_start) bcnt = busy_len;
      else if (bcnt > 0) bcnt--;
      tx_busy = (bcnt != 0);
      if (tx_start0) bcnt0 = 3;
      else if (bcnt0 > 0) bcnt0--;
      tx_busy0 = (bcnt0 != 0);
      @(posedge clk);
      #1;
      req_valid  = req_valid & ~(hs & oneshot);
      req_valid0 = req_valid0 & ~hs0;
   endtask

   task automatic runUntil(input int n_log, input int bound, input string name);
      int c = 0;
      while (!(log_q.size() >= n_log && !active) && c < bound) begin
         cycle();
         c++;
      end
      if (!(log_q.size() >= n_log && !active)) timeoutFail(name);
   endtask

   task automatic clearLogs();
      log_q.delete();
      hs_q.delete();
      for (int k = 0; k < N; k++) rdy_cnt[k] = 0;
   endtask

   task automatic applyStimulus(input vec_t v);
      req_data[v.id*W +: W] = v.word;
      oneshot[v.id]   = 1'b1;
      req_valid[v.id] = 1'b1;
   endtask

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [7:0] exp_seq [8];
      int total, wait_c, bad, c;

      rst = 1'b1;
      req_data = '0; req_valid = '0; req_data0 = '0; req_valid0 = '0;
      oneshot = '0; tx_busy = 1'b0; tx_busy0 = 1'b0;
      busy_len = 40; bcnt = 0; bcnt0 = 0; overlap = 0; overlap0 = 0;
      vecs[0] = '{2, 8'h5A, 8'hF2};
      vecs[1] = '{0, 8'hA5, 8'hF0};
      vecs[2] = '{1, 8'hFF, 8'hF1};
      vecs[3] = '{3, 8'h00, 8'hF3};

      repeat (3) cycle();
      checkOutput("rst_active", active, 0);
      checkOutput("rst_start", tx_start, 0);
      checkOutput("rst_data", tx_data, 0);
      checkOutput("rst_grant", grant_id, 0);
      checkOutput("rst_ready", req_ready, 0);
      checkOutput("rst_active0", active0, 0);
      rst = 1'b0;

      // Single-requester transactions, one table entry each.
      for (int v = 0; v < 4; v++) begin
         clearLogs();
         applyStimulus(vecs[v]);
         runUntil(2, 300, $sformatf("vec%0d_timeout", v));
         total = 0;
         for (int k = 0; k < N; k++) total += rdy_cnt[k];
         checkOutput($sformatf("vec%0d_tag", v), logAt(0), vecs[v].exp_tag);
         checkOutput($sformatf("vec%0d_word", v), logAt(1), vecs[v].word);
         checkOutput($sformatf("vec%0d_nlog", v), log_q.size(), 2);
         checkOutput($sformatf("vec%0d_ready", v), rdy_cnt[vecs[v].id], 1);
         checkOutput($sformatf("vec%0d_ready_total", v), total, 1);
         checkOutput($sformatf("vec%0d_grant", v), grant_id, vecs[v].id);
      end

      // All four requesters valid at once: strict rotation 0..3.
      clearLogs();
      for (int k = 0; k < N; k++) req_data[k*W +: W] = 8'h10 + 8'(k);
      oneshot = 4'hF;
      req_valid = 4'hF;
      runUntil(8, 1000, "all_timeout");
      exp_seq = '{8'hF0, 8'h10, 8'hF1, 8'h11, 8'hF2, 8'h12, 8'hF3, 8'h13};
      for (int i = 0; i < 8; i++) checkOutput($sformatf("all_tx%0d", i), logAt(i), exp_seq[i]);
      checkOutput("all_nhs", hs_q.size(), 4);
      for (int i = 0; i < 4; i++) checkOutput($sformatf("all_hs%0d", i), hs_q[i], i);
      for (int k = 0; k < N; k++) checkOutput($sformatf("all_ready%0d", k), rdy_cnt[k], 1);

      // Untagged instance: ready one cycle after valid, start the cycle after that.
      req_data0[15:8] = 8'hC3;
      req_valid0 = 4'b0010;
      cycle();
      checkOutput("notag_ready_n", s_ready0, 4'b0000);
      cycle();
      checkOutput("notag_ready_n1", s_ready0, 4'b0010);
      checkOutput("notag_start_n1", s_start0, 0);
      cycle();
      checkOutput("notag_start_n2", s_start0, 1);
      checkOutput("notag_data_n2", s_data0, 8'hC3);
      checkOutput("notag_ready_n2", s_ready0, 4'b0000);
      c = 0;
      while (active0 && c < 50) begin cycle(); c++; end
      if (active0) timeoutFail("notag_timeout");
      checkOutput("notag_nlog", log0_q.size(), 1);
      checkOutput("notag_grant", grant_id0, 1);

      // Requester 3 streams continuously; requester 0 joins mid-frame and is not starved.
      busy_len = 20;
      clearLogs();
      req_data[31:24] = 8'h33;
      req_data[7:0]   = 8'h44;
      oneshot   = 4'b0000;
      req_valid = 4'b1000;
      repeat (8) cycle();
      oneshot[0]   = 1'b1;
      req_valid[0] = 1'b1;
      c = 0;
      while (log_q.size() < 6 && c < 500) begin cycle(); c++; end
      if (log_q.size() < 6) timeoutFail("mix_timeout6");
      oneshot[3] = 1'b1;
      runUntil(8, 500, "mix_timeout8");
      exp_seq = '{8'hF3, 8'h33, 8'hF0, 8'h44, 8'hF3, 8'h33, 8'hF3, 8'h33};
      for (int i = 0; i < 8; i++) checkOutput($sformatf("mix_tx%0d", i), logAt(i), exp_seq[i]);
      checkOutput("mix_hs1", hs_q[1], 0);
      checkOutput("mix_valid", req_valid, 0);

      // Long busy: no progress and no extra start until the transmitter frees up.
      busy_len = 200;
      clearLogs();
      req_data[15:8] = 8'h99;
      oneshot   = 4'b0010;
      req_valid = 4'b0010;
      c = 0;
      while (log_q.size() < 1 && c < 20) begin cycle(); c++; end
      if (log_q.size() < 1) timeoutFail("busy_tag_timeout");
      wait_c = 0;
      bad = 0;
      while (tx_busy && wait_c < 400) begin
         cycle();
         wait_c++;
         if (!active || s_ready != 0) bad++;
      end
      checkOutput("busy_wait_cycles", wait_c, 200);
      checkOutput("busy_held_wait", bad, 0);
      checkOutput("busy_no_extra", log_q.size(), 1);
      cycle();
      checkOutput("busy_ready_after", s_ready, 4'b0010);
      runUntil(2, 600, "busy_data_timeout");
      checkOutput("busy_word", logAt(1), 8'h99);
      busy_len = 10;

      // Reset in the data start-pulse cycle; the waiting requester 0 must survive it.
      clearLogs();
      req_data[23:16] = 8'h77;
      req_data[7:0]   = 8'h3C;
      oneshot   = 4'b0101;
      req_valid = 4'b0100;
      c = 0;
      while (!s_hs[2] && c < 200) begin
         cycle();
         c++;
         if (log_q.size() >= 1) req_valid[0] = 1'b1;
      end
      if (!s_hs[2]) timeoutFail("rst_hs_timeout");
      checkOutput("pre_rst_start", tx_start, 1);
      checkOutput("pre_rst_active", active, 1);
      rst = 1'b1;
      #1;
      checkOutput("mid_rst_active", active, 0);
      checkOutput("mid_rst_start", tx_start, 0);
      checkOutput("mid_rst_ready", req_ready, 0);
      checkOutput("mid_rst_grant", grant_id, 0);
      repeat (3) cycle();
      rst = 1'b0;
      clearLogs();
      runUntil(2, 200, "post_rst_timeout");
      checkOutput("post_rst_tag", logAt(0), 8'hF0);
      checkOutput("post_rst_word", logAt(1), 8'h3C);
      checkOutput("post_rst_hs", hs_q[0], 0);
      checkOutput("post_rst_grant", grant_id, 0);
      checkOutput("post_rst_valid", req_valid, 0);

      checkOutput("start_while_busy", overlap, 0);
      checkOutput("start_while_busy0", overlap0, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
